// File: rtl/cnt_report_fmt_if.sv
// Byte handshake between the report formatter and uart_tx.
// The formatter drives din/empty; uart_tx answers with re.
interface cnt_report_fmt_if;
    logic [7:0] din;
    logic       empty;
    logic       re;

    modport master (output din, output empty, input re);
    modport slave  (input din, input empty, output re);
endinterface

// File: rtl/cnt_report_fmt.sv
// Formats an 8-bit value as the ASCII line "CNT: ddd\r\n" and streams it
// byte by byte to uart_tx. Strobes that arrive mid-line are coalesced into
// at most one follow-up line that carries the latest value.
module cnt_report_fmt #(
    parameter int PREFIX_LEN = 5,
    parameter int MSG_LEN    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         i_val,
    input  logic               i_val_stb,
    output logic               o_busy,
    cnt_report_fmt_if.master   tx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] DIG_IDX  = 4'(PREFIX_LEN);
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_cur_val, w_cur_val_nxt;
    logic [7:0]  r_pend_val, w_pend_val_nxt;
    logic        r_pending, w_pending_nxt;
    logic        r_re_q;
    logic [7:0]  r_din;
    logic        r_empty;
    logic        r_busy;
    logic        w_re_p;
    logic [23:0] w_digits;
    logic [7:0]  w_byte;

    // Three zero-padded ASCII decimal digits of a byte value.
    function automatic logic [23:0] to_ascii3(input logic [7:0] v);
        logic [7:0] h, t, o;
        h = v / 8'd100;
        t = (v / 8'd10) % 8'd10;
        o = v % 8'd10;
        return {8'h30 + h, 8'h30 + t, 8'h30 + o};
    endfunction

    // Prefix byte "CNT: " at position p.
    function automatic logic [7:0] prefix_byte(input logic [3:0] p);
        case (p)
            4'd0:    return 8'h43;
            4'd1:    return 8'h4E;
            4'd2:    return 8'h54;
            4'd3:    return 8'h3A;
            default: return 8'h20;
        endcase
    endfunction

    assign w_re_p = tx.re & ~r_re_q;

    // Byte currently selected by idx: prefix, three digits, CR, LF.
    always_comb begin
        w_byte   = 8'h00;
        w_digits = to_ascii3(r_cur_val);
        if (r_idx < DIG_IDX) begin
            w_byte = prefix_byte(r_idx);
        end else begin
            case (r_idx - DIG_IDX)
                4'd0:    w_byte = w_digits[23:16];
                4'd1:    w_byte = w_digits[15:8];
                4'd2:    w_byte = w_digits[7:0];
                4'd3:    w_byte = 8'h0D;
                default: w_byte = 8'h0A;
            endcase
        end
    end

    // Next-state logic: line sequencing plus coalescing of late strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cur_val_nxt  = r_cur_val;
        w_pend_val_nxt = r_pend_val;
        w_pending_nxt  = r_pending;
        case (r_state)
            IDLE: begin
                if (i_val_stb) begin
                    w_cur_val_nxt = i_val;
                    w_idx_nxt     = 4'd0;
                    w_state_nxt   = OFFER;
                end
            end
            OFFER: begin
                // Accept only once the byte is actually visible on din.
                if (w_re_p && !r_empty) begin
                    w_state_nxt = GAP;
                end
                if (i_val_stb) begin
                    w_pend_val_nxt = i_val;
                    w_pending_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (r_idx != LAST_IDX) begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = OFFER;
                    if (i_val_stb) begin
                        w_pend_val_nxt = i_val;
                        w_pending_nxt  = 1'b1;
                    end
                end else if (r_pending) begin
                    // Queued line starts now; a coincident strobe queues the one after.
                    w_cur_val_nxt = r_pend_val;
                    w_idx_nxt     = 4'd0;
                    w_state_nxt   = OFFER;
                    w_pending_nxt = i_val_stb;
                    if (i_val_stb) begin
                        w_pend_val_nxt = i_val;
                    end
                end else if (i_val_stb) begin
                    // Strobe on the last GAP cycle acts as a fresh start.
                    w_cur_val_nxt = i_val;
                    w_idx_nxt     = 4'd0;
                    w_state_nxt   = OFFER;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control and value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= 4'd0;
            r_cur_val  <= 8'h00;
            r_pend_val <= 8'h00;
            r_pending  <= 1'b0;
            r_re_q     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cur_val  <= w_cur_val_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_pending  <= w_pending_nxt;
            r_re_q     <= tx.re;
        end
    end

    // Registered outputs, one cycle behind the state; din holds while not offering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din   <= 8'h00;
            r_empty <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_empty <= (r_state != OFFER);
            r_busy  <= (r_state != IDLE) | r_pending;
            if (r_state == OFFER) begin
                r_din <= w_byte;
            end
        end
    end

    assign tx.din   = r_din;
    assign tx.empty = r_empty;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_cnt_report_fmt.sv
// Bench for cnt_report_fmt: table of report values with hand-written digits,
// plus directed sequences for latency, held re, coalescing, reset and end collision.
module tb_cnt_report_fmt;

    logic       clk;
    logic       rst_n;
    logic [7:0] val;
    logic       val_stb;
    logic       busy;

    cnt_report_fmt_if bus ();

    cnt_report_fmt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_val     (val),
        .i_val_stb (val_stb),
        .o_busy    (busy),
        .tx        (bus)
    );

    typedef struct {
        logic [7:0]  val;
        logic [23:0] digits;
    } vec_t;

    vec_t vecs [6];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [23:0] d);
        case (i)
            0:       return 8'h43;
            1:       return 8'h4E;
            2:       return 8'h54;
            3:       return 8'h3A;
            4:       return 8'h20;
            5:       return d[23:16];
            6:       return d[15:8];
            7:       return d[7:0];
            8:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic wait_offer();
        int n = 0;
        while (bus.empty !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.empty !== 1'b0) begin
            check8("offer timeout", {7'd0, bus.empty}, 8'h00);
        end
    endtask

    // uart_tx model: take the offered byte with a one-cycle re pulse.
    task automatic take_byte(output logic [7:0] b);
        int n = 0;
        wait_offer();
        b = bus.din;
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        while (bus.empty !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.empty !== 1'b1) begin
            check8("gap timeout", {7'd0, bus.empty}, 8'h01);
        end
    endtask

    task automatic strobe(input logic [7:0] v);
        val     = v;
        val_stb = 1'b1;
        @(negedge clk);
        val_stb = 1'b0;
    endtask

    task automatic recv_line(input string tag, input logic [23:0] d, input int start, input int stop);
        logic [7:0] b;
        for (int i = start; i <= stop; i++) begin
            take_byte(b);
            check8($sformatf("%s byte%0d", tag, i), b, exp_byte(i, d));
        end
    endtask

    task automatic idle_check(input string tag);
        repeat (2) @(negedge clk);
        check8({tag, " busy end"}, {7'd0, busy}, 8'h00);
        check8({tag, " empty end"}, {7'd0, bus.empty}, 8'h01);
    endtask

    initial begin
        logic [7:0] b;
        int n;
        bit seen;

        vecs[0] = '{8'd42,  24'h303432};
        vecs[1] = '{8'd0,   24'h303030};
        vecs[2] = '{8'd255, 24'h323535};
        vecs[3] = '{8'd100, 24'h313030};
        vecs[4] = '{8'd9,   24'h303039};
        vecs[5] = '{8'd199, 24'h313939};

        rst_n   = 1'b0;
        bus.re  = 1'b0;
        val     = 8'h00;
        val_stb = 1'b0;
        repeat (3) @(negedge clk);
        check8("reset empty", {7'd0, bus.empty}, 8'h01);
        check8("reset busy",  {7'd0, busy},      8'h00);
        check8("reset din",   bus.din,           8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Strobe-to-offer latency.
        strobe(8'd42);
        check8("lat empty t", {7'd0, bus.empty}, 8'h01);
        @(negedge clk);
        check8("lat empty t+1", {7'd0, bus.empty}, 8'h00);
        check8("lat din t+1", bus.din, 8'h43);
        check8("lat busy", {7'd0, busy}, 8'h01);
        recv_line("lat", 24'h303432, 0, 9);
        idle_check("lat");

        // Table of values.
        for (int v = 0; v < 6; v++) begin
            strobe(vecs[v].val);
            recv_line($sformatf("vec%0d", v), vecs[v].digits, 0, 9);
            idle_check($sformatf("vec%0d", v));
        end

        // re held high for 20 cycles consumes only byte 0.
        strobe(8'd50);
        wait_offer();
        check8("held byte0", bus.din, 8'h43);
        bus.re = 1'b1;
        repeat (20) @(negedge clk);
        check8("held empty", {7'd0, bus.empty}, 8'h00);
        check8("held byte1 waits", bus.din, 8'h4E);
        bus.re = 1'b0;
        @(negedge clk);
        recv_line("held", 24'h303530, 1, 9);
        idle_check("held");

        // re pulses while nothing is offered are ignored.
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        @(negedge clk);
        check8("idle pulse empty", {7'd0, bus.empty}, 8'h01);
        check8("idle pulse busy",  {7'd0, busy},      8'h00);
        strobe(8'd123);
        for (int i = 0; i < 10; i++) begin
            take_byte(b);
            check8($sformatf("gap pulse byte%0d", i), b, exp_byte(i, 24'h313233));
            bus.re = 1'b1;
            @(negedge clk);
            bus.re = 1'b0;
            @(negedge clk);
        end
        idle_check("gap pulse");

        // Coalescing: 6 and 7 arrive during byte 3, only 7 follows.
        strobe(8'd5);
        recv_line("coal1", 24'h303035, 0, 2);
        wait_offer();
        strobe(8'd6);
        strobe(8'd7);
        recv_line("coal1", 24'h303035, 3, 9);
        n = 0;
        while (bus.empty !== 1'b0 && n < 10) begin
            check8("coal busy between", {7'd0, busy}, 8'h01);
            @(negedge clk);
            n++;
        end
        recv_line("coal2", 24'h303037, 0, 9);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.empty === 1'b0) seen = 1'b1;
        end
        check8("coal no third line", {7'd0, seen}, 8'h00);
        check8("coal busy end", {7'd0, busy}, 8'h00);

        // Strobe in the final GAP cycle with nothing pending.
        strobe(8'd20);
        recv_line("endc1", 24'h303230, 0, 8);
        wait_offer();
        check8("endc1 byte9", bus.din, 8'h0A);
        bus.re = 1'b1;
        @(negedge clk);
        bus.re  = 1'b0;
        val     = 8'd77;
        val_stb = 1'b1;
        @(negedge clk);
        val_stb = 1'b0;
        check8("endc gap empty", {7'd0, bus.empty}, 8'h01);
        @(negedge clk);
        check8("endc offer empty", {7'd0, bus.empty}, 8'h00);
        check8("endc offer din", bus.din, 8'h43);
        check8("endc busy", {7'd0, busy}, 8'h01);
        recv_line("endc2", 24'h303737, 0, 9);
        idle_check("endc2");

        // Reset in the middle of a line.
        strobe(8'd88);
        recv_line("rst1", 24'h303838, 0, 5);
        wait_offer();
        rst_n = 1'b0;
        #1;
        check8("rst async empty", {7'd0, bus.empty}, 8'h01);
        check8("rst async busy",  {7'd0, busy},      8'h00);
        check8("rst async din",   bus.din,           8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check8("rst no resume", {7'd0, bus.empty}, 8'h01);
        strobe(8'd9);
        recv_line("rst2", 24'h303039, 0, 9);
        idle_check("rst2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
